// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-flow controller.
// Holds the 2-bit phase encodings, default widths for the length/score and
// tick-counter datapaths, and the helper that turns a snake length into a
// movement period.
package snake_pkg;

    // Phase encodings, also driven straight out on oState
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // Default datapath widths
    localparam int LEN_W_DEF = 10;
    localparam int CNT_W_DEF = 24;

    // Movement period for a given length. The reduction is clamped against
    // the headroom above the floor before subtracting, so a very long snake
    // can never wrap the period around to a huge value.
    function automatic logic [31:0] calcPeriod(
        input logic [31:0] len,
        input logic [31:0] base,
        input logic [31:0] step,
        input logic [31:0] floorVal,
        input logic [31:0] startLen
    );
        logic [31:0] effLen;
        logic [63:0] reduction;
        logic [63:0] maxReduction;
        effLen       = (len < startLen) ? startLen : len;
        reduction    = 64'(effLen - startLen) * 64'(step);
        maxReduction = (base > floorVal) ? 64'(base - floorVal) : 64'd0;
        if (reduction > maxReduction) begin
            reduction = maxReduction;
        end
        calcPeriod = base - reduction[31:0];
    endfunction

endpackage

// File: rtl/snake_game_sequencer_if.sv
// Food-placement handshake between the game sequencer and the world block.
//   oFoodReq : sequencer asks for a new food location (held until acked)
//   iFoodAck : world block has latched a new food location
// master = sequencer side, slave = world block side.
interface snake_game_sequencer_if;

    logic oFoodReq;
    logic iFoodAck;

    modport master (output oFoodReq, input iFoodAck);
    modport slave  (input oFoodReq, output iFoodAck);

endinterface

// File: rtl/snake_tick_timer.sv
// Frame-aligned movement tick generator.
// Ports:
//   Clock, Reset   : system clock, synchronous active-low reset
//   enable_i       : counting allowed (game is in its play phase)
//   freeze_i       : hold counter and pending flag for this cycle
//   load_i         : load reload_i into the counter (start of a game)
//   frameStart_i   : one-cycle pulse at the start of each video frame
//   reload_i       : movement period in clocks, sampled on load or tick
//   tick_o         : one-cycle movement strobe, registered
module snake_tick_timer #(
    parameter int CNT_W = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             enable_i,
    input  logic             freeze_i,
    input  logic             load_i,
    input  logic             frameStart_i,
    input  logic [CNT_W-1:0] reload_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             run;
    logic             due;

    assign run    = enable_i && !freeze_i;
    assign due    = pending_q || (count_q == '0);
    assign tick_o = tick_q;

    // Count down while running; once expired, wait for the next frame start
    // so the snake always moves on a frame boundary. The tick and the reload
    // happen together, which spaces ticks period+1 clocks apart when frame
    // starts are always present.
    always_comb begin
        count_d   = count_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        if (load_i) begin
            count_d   = reload_i;
            pending_d = 1'b0;
        end else if (run) begin
            if (due && frameStart_i) begin
                tick_d    = 1'b1;
                count_d   = reload_i;
                pending_d = 1'b0;
            end else if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count_q   <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

endmodule

// File: rtl/snake_game_sequencer.sv
// Top-level game-flow controller for the snake design.
// Sequences IDLE/PLAY/PAUSE/OVER, produces the frame-aligned movement tick
// (faster for longer snakes), owns the control-off flag, the score counter
// and the food request handshake towards the world block.
// Ports:
//   Clock, Reset   : system clock, synchronous active-low reset
//   iStart, iPause : debounced buttons (levels, act on rising edge)
//   iFrameStart    : frame-start pulse
//   iGameOver      : collision flag (level)
//   iFoodEaten     : head-meets-food pulse
//   iSnakeLenght   : current snake length
//   foodBus        : food request/ack handshake (master side)
//   oIconTick      : movement strobe
//   oCtrlOff       : 1 = movement/control disabled
//   oState         : current phase
//   oScore         : foods eaten this game, saturating
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_BASE   = 2500000,
    parameter int TICK_STEP   = 50000,
    parameter int TICK_MIN    = 500000,
    parameter int START_LEN   = 3,
    parameter int HOLD_FRAMES = 180,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LEN_W       = LEN_W_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic                 iPause,
    input  logic                 iFrameStart,
    input  logic                 iGameOver,
    input  logic                 iFoodEaten,
    input  logic [LEN_W-1:0]     iSnakeLenght,
    snake_game_sequencer_if.master foodBus,
    output logic                 oIconTick,
    output logic                 oCtrlOff,
    output logic [1:0]           oState,
    output logic [LEN_W-1:0]     oScore
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] score_q, score_d;
    logic             foodReq_q, foodReq_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             startPrev_q;
    logic             pausePrev_q;
    logic             startRise;
    logic             pauseRise;
    logic             loadTimer;
    logic [CNT_W-1:0] period;

    assign startRise = iStart && !startPrev_q;
    assign pauseRise = iPause && !pausePrev_q;

    // Period follows the live length; the timer only samples it on reload
    assign period = CNT_W'(calcPeriod(32'(iSnakeLenght), 32'(TICK_BASE),
                                      32'(TICK_STEP), 32'(TICK_MIN),
                                      32'(START_LEN)));

    // Game over and a pause edge both stop counting in the cycle they occur,
    // so a tick that happens to be due then is swallowed rather than leaking
    // out after the phase has left PLAY.
    snake_tick_timer #(
        .CNT_W(CNT_W)
    ) tickTimer (
        .Clock        (Clock),
        .Reset        (Reset),
        .enable_i     (state_q == ST_PLAY),
        .freeze_i     (iGameOver || pauseRise),
        .load_i       (loadTimer),
        .frameStart_i (iFrameStart),
        .reload_i     (period),
        .tick_o       (oIconTick)
    );

    // Phase sequencing, score and food request. A new food request wins over
    // an ack in the same cycle so the eaten food is never lost; repeated
    // eats while a request is outstanding merge into that one request.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        foodReq_d = foodReq_q;
        hold_d    = hold_q;
        loadTimer = 1'b0;

        if (foodBus.iFoodAck && foodReq_q) begin
            foodReq_d = 1'b0;
        end
        if (state_q == ST_PLAY && iFoodEaten) begin
            foodReq_d = 1'b1;
            if (score_q != '1) begin
                score_d = score_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (startRise) begin
                    state_d   = ST_PLAY;
                    score_d   = '0;
                    foodReq_d = 1'b1;
                    loadTimer = 1'b1;
                end
            end
            ST_PLAY: begin
                if (iGameOver) begin
                    state_d = ST_OVER;
                    hold_d  = '0;
                end else if (pauseRise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (iGameOver) begin
                    state_d = ST_OVER;
                    hold_d  = '0;
                end else if (pauseRise) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (hold_q == HOLD_W'(HOLD_FRAMES)) begin
                    state_d = ST_IDLE;
                end else if (iFrameStart) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registers. Edge detectors come out of reset at 1 so a button that is
    // already held when reset releases does not count as a press.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            foodReq_q   <= 1'b0;
            hold_q      <= '0;
            startPrev_q <= 1'b1;
            pausePrev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            foodReq_q   <= foodReq_d;
            hold_q      <= hold_d;
            startPrev_q <= iStart;
            pausePrev_q <= iPause;
        end
    end

    assign foodBus.oFoodReq = foodReq_q;
    assign oCtrlOff         = (state_q != ST_PLAY);
    assign oState           = state_q;
    assign oScore           = score_q;

endmodule

// File: doc/snake_game_sequencer.md
Name: snake_game_sequencer

Overview:
Top-level game-flow controller for the snake design. It sequences the IDLE/PLAY/PAUSE/OVER phases and produces the frame-aligned movement tick, replacing the free-running tick. Tick rate speeds up with snake length. It also owns the global control-off flag, the score counter, and the req/ack handshake that asks the world block for a new food location.

Parameters:
TICK_BASE, 2500000, move period in clocks at START_LEN
TICK_STEP, 50000, period reduction per length unit above START_LEN
TICK_MIN, 500000, floor on move period
START_LEN, 3, initial snake length; shorter lengths are treated as START_LEN
HOLD_FRAMES, 180, frames spent in OVER before auto-return to IDLE
CNT_W, 24, width of tick counter; must hold TICK_BASE
LEN_W, 10, width of length and score

Ports:
Clock  in  1  VGA-domain system clock
Reset  in  1  synchronous, active-low reset
iStart  in  1  debounced start button, level
iPause  in  1  debounced pause button, level
iFrameStart  in  1  one-cycle pulse at start of each video frame
iGameOver  in  1  collision flag from icon block, level
iFoodEaten  in  1  one-cycle pulse when head meets food
iSnakeLenght  in  LEN_W  current snake length
iFoodAck  in  1  world block has latched a new food location
oIconTick  out  1  one-cycle movement strobe
oCtrlOff  out  1  1 = movement/control disabled
oFoodReq  out  1  request new food location
oState  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
oScore  out  LEN_W  foods eaten this game, saturating

Behaviour:
- Reset (Reset==0 at a Clock edge) gives oState=IDLE, oCtrlOff=1, oIconTick=0, oFoodReq=0, oScore=0, counter=0, pending=0, hold=0.
- Reset also sets the start/pause edge-detect registers to 1, so a button held through reset does not trigger.
- Reset asserted mid-game returns to IDLE in one cycle and drops any outstanding request.
- Start and pause act on rising edges only (registered previous value).
- IDLE: oCtrlOff=1.
  - Start edge -> PLAY; oScore cleared; counter loaded with period P; oFoodReq set (initial placement).
- PLAY: oCtrlOff=0.
  - iGameOver=1 -> OVER. This has priority over pause and over a tick in the same cycle; no tick is issued.
  - Otherwise a pause edge -> PAUSE.
- PAUSE: oCtrlOff=1; counter and pending are frozen.
  - Pause edge -> PLAY, resuming the frozen count.
  - iGameOver=1 -> OVER.
- OVER: oCtrlOff=1; hold counts iFrameStart pulses.
  - When hold reaches HOLD_FRAMES -> IDLE.
  - Start edges are ignored while in OVER.
- Period P = TICK_BASE - (max(len,START_LEN) - START_LEN) * TICK_STEP, clamped to be at least TICK_MIN.
  - Subtraction must not underflow: compute the reduction first and clamp before the subtract.
  - P is sampled from iSnakeLenght only at reload.
- Tick timing in PLAY:
  - The counter decrements each cycle while nonzero.
  - At 0 it sets pending.
  - On a cycle with pending (or counter==0) and iFrameStart==1: oIconTick=1 on the next cycle, pending cleared, counter reloaded with P.
  - With iFrameStart held high, ticks are spaced P+1 cycles apart.
  - Ticks are never issued outside PLAY.
- Food handshake:
  - An iFoodEaten pulse in PLAY does oScore+1 (saturating at 2^LEN_W-1) and sets oFoodReq on the next cycle.
  - oFoodReq holds until iFoodAck is sampled 1, then clears on the next cycle.
  - iFoodEaten while oFoodReq is already high increments the score but coalesces (no second request).
  - iFoodAck while oFoodReq=0 is ignored.
  - iFoodEaten outside PLAY is ignored.
- oFoodReq stays pending across PAUSE/OVER transitions until acked. It is cleared only by Reset or ack.

Decomposition:
- Package snake_pkg holds:
  - state encodings ST_IDLE/ST_PLAY/ST_PAUSE/ST_OVER (2-bit);
  - LEN_W and CNT_W defaults;
  - a period-compute function (saturating subtract with floor).
- One sub-module: snake_tick_timer. It contains the counter, the pending flag and frame alignment. Inputs: enable, freeze, reload value. Output: tick.
- The FSM, edge detect, score and handshake stay in the top module.

Test Plan:
(bench params: TICK_BASE=20, TICK_STEP=2, TICK_MIN=6, START_LEN=3, HOLD_FRAMES=2)
1. Reset low 2 cycles with iStart=1, then release -> oState=00, oCtrlOff=1, no transition until iStart goes 0 then 1; after that oState=01 and oFoodReq=1.
2. PLAY, iFrameStart=1 constantly, length 3 -> oIconTick pulses every 21 cycles. Length 6 -> every 15. Length 10 and length 50 -> every 7 (clamped).
3. PLAY, counter expires, iFrameStart pulsed 5 cycles later -> exactly one oIconTick, 1 cycle after that pulse. Pause edge mid-count, then resume 30 cycles later -> remaining count preserved, no tick during PAUSE.
4. Two iFoodEaten pulses 3 cycles apart, iFoodAck held 0 -> oScore=2, single oFoodReq high; ack on cycle 10 -> oFoodReq=0 on cycle 11. Ack with no request -> no change.
5. iGameOver and a pause edge in the same cycle as a due tick -> oState=11, no oIconTick, oCtrlOff=1. After 2 iFrameStart pulses -> oState=00. Start edges during OVER are ignored.
6. Score at 1023 plus iFoodEaten -> oScore stays 1023. Reset driven low mid-PLAY with oFoodReq=1 -> all outputs return to reset values the next cycle.
